// File: rtl/maquina_preparo_if.sv
// Payment status bus between the payment FSM (master) and the preparation
// sequencer (slave): status and product code one way, the payment timeout back.
interface maquina_preparo_if;
  logic [1:0] STATUS;
  logic [1:0] PRODUTO;
  logic       TIMER;

  modport master (output STATUS, output PRODUTO, input TIMER);
  modport slave  (input STATUS, input PRODUTO, output TIMER);
endinterface

// File: rtl/maquina_preparo.sv
// Drink-preparation sequencer: watches payment status, times out slow payments,
// runs water/powder/milk/cup phases and raises a refund pulse on bad payments.
module maquina_preparo #(
  parameter int CW          = 8,
  parameter int T_PAGAMENTO = 50,
  parameter int T_AGUA      = 8,
  parameter int T_PO        = 4,
  parameter int T_LEITE     = 6,
  parameter int T_ENTREGA   = 3
) (
  input  logic                CLK,
  input  logic                RESET_N,
  maquina_preparo_if.slave    pag,
  output logic                VALVULA_AGUA,
  output logic                DOSADOR_PO,
  output logic                VALVULA_LEITE,
  output logic                LIBERA_COPO,
  output logic                ESTORNO,
  output logic                PRONTO,
  output logic [2:0]          ETAPA
);

  localparam logic [2:0] S_OCIOSO   = 3'd0;
  localparam logic [2:0] S_COBRANDO = 3'd1;
  localparam logic [2:0] S_AGUA     = 3'd2;
  localparam logic [2:0] S_PO       = 3'd3;
  localparam logic [2:0] S_LEITE    = 3'd4;
  localparam logic [2:0] S_ENTREGA  = 3'd5;
  localparam logic [2:0] S_ESTORNO  = 3'd6;

  localparam logic [1:0] ST_ESPERA   = 2'b00;
  localparam logic [1:0] ST_PAGANDO  = 2'b01;
  localparam logic [1:0] ST_ERRADO   = 2'b10;
  localparam logic [1:0] ST_PAGO     = 2'b11;

  localparam logic [1:0] P_LEITE     = 2'b01;
  localparam logic [1:0] P_INVALIDO  = 2'b10;
  localparam logic [1:0] P_FORTE     = 2'b11;

  localparam logic [CW-1:0] LIM_PAG   = CW'(T_PAGAMENTO - 1);
  localparam logic [CW-1:0] LIM_AGUA  = CW'(T_AGUA - 1);
  localparam logic [CW-1:0] LIM_PO1   = CW'(T_PO - 1);
  localparam logic [CW-1:0] LIM_PO2   = CW'(2 * T_PO - 1);
  localparam logic [CW-1:0] LIM_LEITE = CW'(T_LEITE - 1);
  localparam logic [CW-1:0] LIM_ENT_F = CW'(T_ENTREGA - 1);
  localparam logic [CW-1:0] LIM_ENT   = CW'(T_ENTREGA);
  localparam logic [CW-1:0] UM        = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cap;
  logic [CW-1:0] lim_po;
  logic [1:0]    prod_q, prod_d;
  logic          timer_q, timer_d;
  logic          armado_q;

  assign lim_po = (prod_q == P_FORTE) ? LIM_PO2 : LIM_PO1;

  // Next-state decode; cap is where the counter parks so long holds never wrap
  // back into a value that would re-fire the cup release or the refund pulse.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    timer_d = 1'b0;
    cap     = '1;
    case (state_q)
      S_OCIOSO: begin
        if (armado_q) begin
          case (pag.STATUS)
            ST_PAGANDO: state_d = S_COBRANDO;
            ST_PAGO: begin
              prod_d  = pag.PRODUTO;
              state_d = (pag.PRODUTO == P_INVALIDO) ? S_ESTORNO : S_AGUA;
            end
            ST_ERRADO: state_d = S_ESTORNO;
            default:   state_d = S_OCIOSO;
          endcase
        end
      end
      S_COBRANDO: begin
        cap = LIM_PAG;
        case (pag.STATUS)
          ST_PAGO: begin
            prod_d  = pag.PRODUTO;
            state_d = (pag.PRODUTO == P_INVALIDO) ? S_ESTORNO : S_AGUA;
          end
          ST_ERRADO:  state_d = S_ESTORNO;
          ST_ESPERA:  state_d = S_OCIOSO;
          default:    timer_d = timer_q | (cnt_q == LIM_PAG);
        endcase
      end
      S_AGUA: begin
        if (cnt_q == LIM_AGUA) state_d = S_PO;
      end
      S_PO: begin
        if (cnt_q == lim_po) state_d = (prod_q == P_LEITE) ? S_LEITE : S_ENTREGA;
      end
      S_LEITE: begin
        if (cnt_q == LIM_LEITE) state_d = S_ENTREGA;
      end
      S_ENTREGA: begin
        cap = LIM_ENT;
        // The cup phase always runs to completion before a release to idle.
        if (cnt_q >= LIM_ENT_F && pag.STATUS == ST_ESPERA) state_d = S_OCIOSO;
      end
      S_ESTORNO: begin
        cap = UM;
        if (pag.STATUS == ST_ESPERA) state_d = S_OCIOSO;
      end
      default: state_d = S_OCIOSO;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (cnt_q == cap)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + UM;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_OCIOSO;
      cnt_q    <= '0;
      prod_q   <= 2'b00;
      timer_q  <= 1'b0;
      armado_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      timer_q <= timer_d;
      if (pag.STATUS == ST_ESPERA) armado_q <= 1'b1;
    end
  end

  assign pag.TIMER     = timer_q;
  assign VALVULA_AGUA  = (state_q == S_AGUA);
  assign DOSADOR_PO    = (state_q == S_PO);
  assign VALVULA_LEITE = (state_q == S_LEITE);
  assign LIBERA_COPO   = (state_q == S_ENTREGA) && (cnt_q < LIM_ENT);
  assign ESTORNO       = (state_q == S_ESTORNO) && (cnt_q == '0);
  assign PRONTO        = (state_q == S_OCIOSO) && armado_q;
  assign ETAPA         = state_q;

endmodule

// File: tb/tb_maquina_preparo.sv
// Directed bench for maquina_preparo: table of per-cycle vectors for the brew,
// refund and timeout flows, plus a hand sequence for reset during the milk phase.
module tb_maquina_preparo;

  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_PRONTO = 7'b0000001;
  localparam logic [6:0] O_EST    = 7'b0000010;
  localparam logic [6:0] O_COPO   = 7'b0000100;
  localparam logic [6:0] O_LEITE  = 7'b0001000;
  localparam logic [6:0] O_PO     = 7'b0010000;
  localparam logic [6:0] O_AGUA   = 7'b0100000;
  localparam logic [6:0] O_TIMER  = 7'b1000000;

  typedef struct {
    logic [1:0] status;
    logic [1:0] produto;
    int         n;
    logic [2:0] etapa;
    logic [6:0] outs;
    string      name;
  } vec_t;

  logic       CLK;
  logic       RESET_N;
  logic       VALVULA_AGUA, DOSADOR_PO, VALVULA_LEITE, LIBERA_COPO, ESTORNO, PRONTO;
  logic [2:0] ETAPA;
  int         checks;
  int         errors;
  vec_t       vecs[$];

  maquina_preparo_if bus ();

  maquina_preparo dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .pag           (bus),
    .VALVULA_AGUA  (VALVULA_AGUA),
    .DOSADOR_PO    (DOSADOR_PO),
    .VALVULA_LEITE (VALVULA_LEITE),
    .LIBERA_COPO   (LIBERA_COPO),
    .ESTORNO       (ESTORNO),
    .PRONTO        (PRONTO),
    .ETAPA         (ETAPA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic addVec(input logic [1:0] s, input logic [1:0] p, input int n,
                        input logic [2:0] e, input logic [6:0] o, input string nm);
    vec_t v;
    v.status = s; v.produto = p; v.n = n; v.etapa = e; v.outs = o; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [1:0] p);
    bus.STATUS  = s;
    bus.PRODUTO = p;
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] e, input logic [6:0] o);
    logic [6:0] act;
    act = {bus.TIMER, VALVULA_AGUA, DOSADOR_PO, VALVULA_LEITE, LIBERA_COPO, ESTORNO, PRONTO};
    checks++;
    if (ETAPA !== e || act !== o) begin
      errors++;
      $display("[TB] FAIL %s: got etapa=%0d outs=%b, expected etapa=%0d outs=%b (t=%0t)",
               nm, ETAPA, act, e, o, $time);
    end
  endtask

  task automatic cycleCheck(input string nm, input logic [2:0] e, input logic [6:0] o);
    @(posedge CLK);
    #1;
    checkOutput(nm, e, o);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Outputs are {TIMER, AGUA, PO, LEITE, COPO, ESTORNO, PRONTO}
    addVec(2'b11, 2'b00, 2, 3'd0, O_NONE,   "not_armed");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "armed");
    // plain; product changed after entry must not matter
    addVec(2'b11, 2'b00, 8, 3'd2, O_AGUA,   "plain_agua");
    addVec(2'b11, 2'b01, 4, 3'd3, O_PO,     "plain_po");
    addVec(2'b11, 2'b01, 3, 3'd5, O_COPO,   "plain_copo");
    addVec(2'b11, 2'b01, 2, 3'd5, O_NONE,   "plain_hold");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "plain_idle");
    // with milk
    addVec(2'b11, 2'b01, 8, 3'd2, O_AGUA,   "milk_agua");
    addVec(2'b11, 2'b01, 4, 3'd3, O_PO,     "milk_po");
    addVec(2'b11, 2'b01, 6, 3'd4, O_LEITE,  "milk_leite");
    addVec(2'b11, 2'b01, 3, 3'd5, O_COPO,   "milk_copo");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "milk_idle");
    // strong
    addVec(2'b11, 2'b11, 8, 3'd2, O_AGUA,   "strong_agua");
    addVec(2'b11, 2'b11, 8, 3'd3, O_PO,     "strong_po");
    addVec(2'b11, 2'b11, 3, 3'd5, O_COPO,   "strong_copo");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "strong_idle");
    // invalid product
    addVec(2'b11, 2'b10, 1, 3'd6, O_EST,    "inval_pulse");
    addVec(2'b11, 2'b10, 3, 3'd6, O_NONE,   "inval_hold");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "inval_idle");
    // timeout then incorrect payment
    addVec(2'b01, 2'b00, 50, 3'd1, O_NONE,  "cob_wait");
    addVec(2'b01, 2'b00, 3, 3'd1, O_TIMER,  "cob_timer");
    addVec(2'b10, 2'b00, 1, 3'd6, O_EST,    "err_pulse");
    addVec(2'b10, 2'b00, 2, 3'd6, O_NONE,   "err_hold");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "err_idle");
    // paid on the timeout edge
    addVec(2'b01, 2'b00, 50, 3'd1, O_NONE,  "race_wait");
    addVec(2'b11, 2'b00, 8, 3'd2, O_AGUA,   "race_agua");
    addVec(2'b11, 2'b00, 4, 3'd3, O_PO,     "race_po");
    addVec(2'b11, 2'b00, 3, 3'd5, O_COPO,   "race_copo");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "race_idle");
    // abandon payment
    addVec(2'b01, 2'b00, 2, 3'd1, O_NONE,   "cob_short");
    addVec(2'b00, 2'b00, 1, 3'd0, O_PRONTO, "cob_abandon");

    RESET_N = 1'b0;
    applyStimulus(2'b00, 2'b00);
    #12;
    checkOutput("reset_state", 3'd0, O_NONE);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].status, vecs[i].produto);
      for (int k = 0; k < vecs[i].n; k++)
        cycleCheck(vecs[i].name, vecs[i].etapa, vecs[i].outs);
    end

    // Reset asserted mid-cycle during the milk phase
    applyStimulus(2'b11, 2'b01);
    repeat (12) @(posedge CLK);
    cycleCheck("pre_reset_leite", 3'd4, O_LEITE);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, O_NONE);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++)
      cycleCheck("post_reset_held", 3'd0, O_NONE);
    applyStimulus(2'b00, 2'b00);
    cycleCheck("post_reset_arm", 3'd0, O_PRONTO);
    applyStimulus(2'b11, 2'b11);
    cycleCheck("post_reset_brew", 3'd2, O_AGUA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
